// File: rtl/fns_cac_encoder_seq.sv
// Sequential Fibonacci-numeral-system crosstalk-avoidance encoder: one codeword digit
// per clock, MSB first, with the TSV bus only updated once a whole codeword is resolved.
module fns_cac_encoder_seq #(
  parameter int N_TSV  = 9,
  parameter int MODE   = 0,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [N_TSV-1:0]  tsv,
  output logic              tsv_valid,
  output logic              range_err,
  output logic              dbg_state_o
);

  // Handshake: a word transfers on a rising edge where in_valid && in_ready; in_ready
  // depends only on state, and in_data is never looked at outside that edge.

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  function automatic int unsigned fib(input int n);
    int unsigned a, b, t;
    a = 1;
    b = 1;
    for (int i = 3; i <= n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  // Packed tables indexed by digit: weights w[k] = F(k+2) or prefix sums S[k].
  function automatic logic [N_TSV*DATA_W-1:0] calc_table(input bit sums);
    logic [N_TSV*DATA_W-1:0] t;
    int unsigned acc;
    t   = '0;
    acc = 0;
    for (int i = 0; i < N_TSV; i++) begin
      t[i*DATA_W +: DATA_W] = sums ? DATA_W'(acc) : DATA_W'(fib(i + 2));
      acc = acc + fib(i + 2);
    end
    return t;
  endfunction

  localparam int unsigned MAX_VAL = (MODE == 0) ? fib(N_TSV + 2) - 1 : fib(N_TSV + 3) - 2;
  localparam logic [DATA_W-1:0]       MAX_W = DATA_W'(MAX_VAL);
  localparam logic [N_TSV*DATA_W-1:0] W_TAB = calc_table(1'b0);
  localparam logic [N_TSV*DATA_W-1:0] S_TAB = calc_table(1'b1);
  localparam logic [N_TSV-1:0]        ONE_V = N_TSV'(1);
  localparam logic [4:0]              K_TOP = 5'(N_TSV - 1);

  state_t              state_q;
  logic [4:0]          k_q;
  logic [DATA_W-1:0]   r_q, r_d;
  logic [N_TSV-1:0]    shadow_q, shadow_d;
  logic [N_TSV-1:0]    tsv_q;
  logic                tsv_valid_q, range_err_q;
  logic [DATA_W-1:0]   w_k, s_k;
  logic                digit;

  always_comb begin
    w_k = '0;
    s_k = '0;
    for (int i = 0; i < N_TSV; i++) begin
      if (k_q == 5'(i)) begin
        w_k = W_TAB[i*DATA_W +: DATA_W];
        s_k = S_TAB[i*DATA_W +: DATA_W];
      end
    end
    // Greedy takes the weight whenever it fits; lazy only when the lower digits
    // alone could not cover the residual.
    digit    = (MODE == 0) ? (r_q >= w_k) : (r_q > s_k);
    r_d      = digit ? (r_q - w_k) : r_q;
    shadow_d = digit ? (shadow_q | (ONE_V << k_q)) : shadow_q;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      r_q         <= '0;
      shadow_q    <= '0;
      tsv_q       <= '0;
      tsv_valid_q <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      tsv_valid_q <= 1'b0;
      range_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (in_data > MAX_W) begin
              range_err_q <= 1'b1;
            end else begin
              r_q      <= in_data;
              shadow_q <= '0;
              k_q      <= K_TOP;
              state_q  <= BUSY;
            end
          end
        end
        BUSY: begin
          r_q      <= r_d;
          shadow_q <= shadow_d;
          if (k_q == 5'd0) begin
            tsv_q       <= shadow_d;
            tsv_valid_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            k_q <= k_q - 5'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign tsv         = tsv_q;
  assign tsv_valid   = tsv_valid_q;
  assign range_err   = range_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fns_cac_encoder_seq.sv
// Bench for fns_cac_encoder_seq: a greedy and a lazy instance (N_TSV=9) driven by directed
// words; a queue of expected responses is drained by a monitor on the falling edge.
module tb_fns_cac_encoder_seq;

  localparam int N  = 9;
  localparam int EW = 44;
  localparam int K_EXACT = 0;
  localparam int K_DEC   = 1;
  localparam int K_ERR   = 2;

  logic             clk;
  logic             rst_n;
  logic [1:0]       in_valid;
  logic [1:0][7:0]  in_data;
  wire  [1:0]       in_ready;
  wire  [1:0][8:0]  tsv;
  wire  [1:0]       tsv_valid;
  wire  [1:0]       range_err;
  wire  [1:0]       dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [EW-1:0] exp_q[$];
  logic [8:0]    prev_tsv [2];
  int            wt [N] = '{1, 2, 3, 5, 8, 13, 21, 34, 55};

  fns_cac_encoder_seq #(.N_TSV(N), .MODE(0), .DATA_W(8)) dut0 (
    .clock(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .tsv(tsv[0]), .tsv_valid(tsv_valid[0]),
    .range_err(range_err[0]), .dbg_state_o(dbg_state[0])
  );

  fns_cac_encoder_seq #(.N_TSV(N), .MODE(1), .DATA_W(8)) dut1 (
    .clock(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .tsv(tsv[1]), .tsv_valid(tsv_valid[1]),
    .range_err(range_err[1]), .dbg_state_o(dbg_state[1])
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, expv, $time);
    end
  endtask

  function automatic logic [EW-1:0] mk(input int kind, input int m, input int val,
                                       input logic [8:0] t, input int c);
    return {2'(kind), 1'(m), 16'(val), t, 16'(c)};
  endfunction

  function automatic int decode(input logic [8:0] t);
    int s = 0;
    for (int i = 0; i < N; i++) if (t[i]) s += wt[i];
    return s;
  endfunction

  function automatic bit lazy_ok(input logic [8:0] t);
    int msb = -1;
    for (int i = 0; i < N; i++) if (t[i]) msb = i;
    for (int i = 0; i < msb; i++) if (!t[i] && !t[i+1]) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst_n) begin
      prev_tsv[0] = tsv[0];
      prev_tsv[1] = tsv[1];
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (tsv_valid[m] && range_err[m]) chk("valid_err_exclusive", 1, 0);
        if (tsv_valid[m] || range_err[m]) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", {30'd0, tsv_valid[m], range_err[m]}, 0);
          end else begin
            e = exp_q.pop_front();
            chk("event_dut", m, {31'd0, e[41]});
            chk("event_cycle", cyc & 32'hffff, {16'd0, e[15:0]});
            if (int'(e[43:42]) == K_ERR) begin
              chk("range_err_seen", range_err[m], 1);
              chk("tsv_kept_on_err", tsv[m], {23'd0, e[24:16]});
            end else begin
              chk("tsv_valid_seen", tsv_valid[m], 1);
              if (int'(e[43:42]) == K_EXACT)
                chk("tsv_codeword", tsv[m], {23'd0, e[24:16]});
              else
                chk("tsv_decoded", decode(tsv[m]), {16'd0, e[40:25]});
              if (m == 0) chk("greedy_no_adjacent_ones", tsv[m] & (tsv[m] >> 1), 0);
              else        chk("lazy_no_adjacent_zeros", lazy_ok(tsv[m]), 1);
            end
          end
        end else begin
          chk("tsv_hold_between_valid", tsv[m], prev_tsv[m]);
        end
        prev_tsv[m] = tsv[m];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input int m);
    int n = 0;
    while (!in_ready[m] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[m]) chk("ready_timeout", 0, 1);
  endtask

  task automatic send(input int m, input int d, input int kind, input logic [8:0] t);
    wait_ready(m);
    in_valid[m] = 1'b1;
    in_data[m]  = 8'(d);
    exp_q.push_back(mk(kind, m, d, t, cyc + 1 + ((kind == K_ERR) ? 0 : N)));
    @(posedge clk);
    #1 in_valid[m] = 1'b0;
    @(negedge clk);
    chk("in_ready_after_accept", in_ready[m], (kind == K_ERR) ? 1 : 0);
  endtask

  task automatic b2b(input int start, input int n);
    int low;
    wait_ready(0);
    in_valid[0] = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_data[0] = 8'(start + i);
      exp_q.push_back(mk(K_DEC, 0, start + i, 9'd0, cyc + 1 + N));
      @(posedge clk);
      @(negedge clk);
      low = 0;
      while (!in_ready[0] && low < 50) begin
        low++;
        @(negedge clk);
      end
      chk("b2b_ready_low_cycles", low, N);
    end
    in_valid[0] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n    = 1'b0;
    in_valid = '0;
    in_data  = '0;
    repeat (2) @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk("reset_tsv", tsv[m], 0);
      chk("reset_tsv_valid", tsv_valid[m], 0);
      chk("reset_range_err", range_err[m], 0);
      chk("reset_in_ready", in_ready[m], 1);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Greedy directed vectors
    send(0, 88, K_EXACT, 9'b101010101);
    send(0, 89, K_ERR,   9'b101010101);
    send(0, 0,  K_EXACT, 9'b000000000);
    // Lazy directed vectors
    send(1, 142, K_EXACT, 9'b111111111);
    send(1, 143, K_ERR,   9'b111111111);
    send(1, 100, K_EXACT, 9'b101101111);
    send(1, 1,   K_EXACT, 9'b000000001);
    drain();

    // Full-range sweeps checked by decoding
    for (int v = 0; v <= 88; v++)  send(0, v, K_DEC, 9'd0);
    for (int v = 0; v <= 142; v++) send(1, v, K_DEC, 9'd0);
    drain();

    // Back-to-back acceptance with in_valid held high
    b2b(20, 5);
    drain();

    // Reset in the 4th BUSY cycle aborts the word
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_data[0]  = 8'd88;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_tsv_zero", tsv[0], 0);
    chk("abort_tsv_valid", tsv_valid[0], 0);
    chk("abort_in_ready", in_ready[0], 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, 5, K_EXACT, 9'b000001000);
    drain();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
